midi_note_scheduler: RTL
========================

// Module: midi_note_scheduler
// PURPOSE
//  Voice scheduler in front of midi_note_sender. Accepts timed note requests
//  (channel, note, velocity, duration). For each accepted request it issues a
//  Note On, holds the voice in a timer slot, and issues the matching Note Off
//  when the duration expires. Serialises all messages onto the single sender.
// PARAMETERS
//  VOICES    4      number of concurrent voice slots (1..8)
//  TICK_DIV  50000  clk cycles per duration tick (1 ms at 50 MHz)
//  DUR_W     8      width of the duration field, in ticks
// PORTS
//  clk           in   1      system clock
//  reset         in   1      async, active-high reset
//  req_valid     in   1      note request present
//  req_ready     out  1      request accepted on clk edge when valid & ready
//  req_channel   in   4      MIDI channel
//  req_note      in   7      note number
//  req_velocity  in   7      Note On velocity
//  req_duration  in   DUR_W  note length in ticks; 0 is treated as 1
//  panic         in   1      1-cycle pulse: release every active voice
//  msg_send      out  1      1-cycle pulse to sender trigger
//  msg_channel   out  4      channel of current message
//  msg_note      out  7      note of current message
//  msg_velocity  out  7      velocity of current message (0 = Note Off form)
//  msg_busy      in   1      sender busy
//  active_count  out  4      number of occupied voice slots
// BEHAVIOUR
//  Reset: msg_send=0, req_ready=0, msg_* = 0, active_count=0, all slots free,
//   tick prescaler=0, FSM=IDLE. Reset mid-message abandons it; no Note Off sent.
//  Slot state: valid, off_pend, channel, note, timer[DUR_W].
//  Tick: free-running prescaler counts 0..TICK_DIV-1; tick pulses at wrap.
//   On tick, every valid slot with timer>0 decrements; 1->0 sets off_pend.
//  req_ready = (FSM==IDLE) & any slot free & !any off_pend.
//  Accept: lowest-index free slot. valid=1, timer=max(duration,1). FSM
//   emits Note On (velocity=req_velocity). A slot loaded on a tick edge is not
//   decremented that tick.
//  Note Off: a message with velocity 0 (sender emits 0x9n,note,0x00).
//  Arbitration in IDLE: a pending Note Off (lowest index first) beats a new
//   request. Slot frees (valid=0, off_pend=0) when its Note Off msg_send fires.
//  panic: sets off_pend on every valid slot; idempotent; no effect on free
//   slots; a Note On in flight completes and its voice is released afterwards.
//  FSM (2-bit):
//   IDLE    -> LOAD on off_pend or accepted request; latch msg_* from source.
//   LOAD    -> if !msg_busy: msg_send=1 for one cycle -> WAIT_HI.
//   WAIT_HI -> WAIT_LO when msg_busy=1, or after 4 cycles without busy
//              (guards against the sender's busy latency).
//   WAIT_LO -> IDLE when msg_busy=0.
//  Throughput: exactly one 3-byte message per FSM loop. msg_* stay stable from
//   LOAD until FSM returns to IDLE.
//  active_count is updated the cycle after allocation or release.
//  Duplicate channel/note requests take separate slots. No deduplication.
//  All slots full: req_ready=0 until a Note Off frees a slot.
// TESTING
//  1 Req ch=2,note=60,vel=100,dur=3 (TICK_DIV=4) -> msg 2/60/100, then after
//    3 ticks msg 2/60/0. active_count goes 1 then 0.
//  2 dur=0 -> Note Off sent after exactly 1 tick.
//  3 Fill VOICES slots -> req_ready=0. First expiry frees slot 0. Next req
//    lands in slot 0.
//  4 Expiry on the same cycle as req_valid -> Note Off sent before Note On.
//  5 panic with 3 active voices -> 3 Note Offs in order slot 0,1,2, then
//    active_count=0.
//  6 reset asserted during WAIT_LO -> outputs at reset values next edge, and
//    no messages after deassert.

Source files
------------

// File: rtl/midi_note_scheduler_if.sv
// midi_note_scheduler_if: note-request handshake and sender message bus of the scheduler
interface midi_note_scheduler_if #(parameter int DUR_W = 8);
    logic             req_valid;
    logic             req_ready;
    logic [3:0]       req_channel;
    logic [6:0]       req_note;
    logic [6:0]       req_velocity;
    logic [DUR_W-1:0] req_duration;
    logic             msg_send;
    logic [3:0]       msg_channel;
    logic [6:0]       msg_note;
    logic [6:0]       msg_velocity;
    logic             msg_busy;
    modport master (
        output req_valid, req_channel, req_note, req_velocity, req_duration, msg_busy,
        input  req_ready, msg_send, msg_channel, msg_note, msg_velocity
    );
    modport slave (
        input  req_valid, req_channel, req_note, req_velocity, req_duration, msg_busy,
        output req_ready, msg_send, msg_channel, msg_note, msg_velocity
    );
endinterface

// File: rtl/midi_note_scheduler.sv
// midi_note_scheduler: holds timed notes in voice slots and serialises their Note On/Off messages onto one sender
module midi_note_scheduler #(
    parameter int VOICES   = 4,
    parameter int TICK_DIV = 50000,
    parameter int DUR_W    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    midi_note_scheduler_if.slave bus,
    input  logic                 panic,
    output logic [3:0]           active_count
);
    localparam int IW = VOICES > 1 ? $clog2(VOICES) : 1;
    localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, WAIT_HI, WAIT_LO} state_t;

    state_t            state, state_nxt;
    logic [PW-1:0]     presc;
    logic              tick;
    logic [VOICES-1:0] valid, off_pend, pend_now;
    logic [3:0]        slot_ch   [VOICES];
    logic [6:0]        slot_note [VOICES];
    logic [DUR_W-1:0]  timer     [VOICES];
    logic [IW-1:0]     free_idx, off_idx, cur_idx;
    logic              cur_off, take_off, accept, send;
    logic [1:0]        hi_cnt;
    logic [3:0]        msg_ch;
    logic [6:0]        msg_note, msg_vel;

    assign tick = presc == PW'(TICK_DIV - 1);

    always_ff @(posedge clk or posedge reset)
        if (reset) presc <= '0;
        else presc <= tick ? '0 : presc + 1'b1;

    // A slot expiring or caught by panic this cycle already counts as pending, so its Note Off wins this edge.
    always_comb begin
        pend_now = '0;
        free_idx = '0;
        off_idx  = '0;
        for (int i = VOICES - 1; i >= 0; i--) begin
            pend_now[i] = off_pend[i] | (valid[i] & (panic | (tick & timer[i] == DUR_W'(1))));
            if (!valid[i]) free_idx = IW'(i);
            if (pend_now[i]) off_idx = IW'(i);
        end
    end

    assign take_off         = state == IDLE && |pend_now;
    assign bus.req_ready    = !reset && state == IDLE && !(&valid) && !(|pend_now);
    assign accept           = bus.req_valid && bus.req_ready;
    assign bus.msg_send     = send;
    assign bus.msg_channel  = msg_ch;
    assign bus.msg_note     = msg_note;
    assign bus.msg_velocity = msg_vel;

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state  <= IDLE;
            hi_cnt <= '0;
        end else begin
            state  <= state_nxt;
            hi_cnt <= state == WAIT_HI ? hi_cnt + 1'b1 : '0;
        end

    // WAIT_HI gives up after four quiet cycles in case the sender never raises busy.
    always_comb begin
        state_nxt = state;
        send      = 1'b0;
        case (state)
            IDLE:    state_nxt = take_off || accept ? LOAD : IDLE;
            LOAD: begin
                send      = !bus.msg_busy;
                state_nxt = bus.msg_busy ? LOAD : WAIT_HI;
            end
            WAIT_HI: state_nxt = bus.msg_busy || hi_cnt == 2'd3 ? WAIT_LO : WAIT_HI;
            default: state_nxt = bus.msg_busy ? WAIT_LO : IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            msg_ch   <= '0;
            msg_note <= '0;
            msg_vel  <= '0;
            cur_idx  <= '0;
            cur_off  <= 1'b0;
        end else if (take_off) begin
            msg_ch   <= slot_ch[off_idx];
            msg_note <= slot_note[off_idx];
            msg_vel  <= '0;
            cur_idx  <= off_idx;
            cur_off  <= 1'b1;
        end else if (accept) begin
            msg_ch   <= bus.req_channel;
            msg_note <= bus.req_note;
            msg_vel  <= bus.req_velocity;
            cur_idx  <= free_idx;
            cur_off  <= 1'b0;
        end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            valid        <= '0;
            off_pend     <= '0;
            active_count <= '0;
            for (int i = 0; i < VOICES; i++) begin
                slot_ch[i]   <= '0;
                slot_note[i] <= '0;
                timer[i]     <= '0;
            end
        end else begin
            for (int i = 0; i < VOICES; i++) begin
                if (accept && free_idx == IW'(i)) begin
                    valid[i]     <= 1'b1;
                    off_pend[i]  <= 1'b0;
                    slot_ch[i]   <= bus.req_channel;
                    slot_note[i] <= bus.req_note;
                    timer[i]     <= bus.req_duration == '0 ? DUR_W'(1) : bus.req_duration;
                end else if (send && cur_off && cur_idx == IW'(i)) begin
                    valid[i]    <= 1'b0;
                    off_pend[i] <= 1'b0;
                end else if (valid[i]) begin
                    if (pend_now[i]) off_pend[i] <= 1'b1;
                    if (tick && timer[i] != '0) timer[i] <= timer[i] - 1'b1;
                end
            end
            active_count <= 4'($countones(valid));
        end
endmodule
